// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle ALU with valid/ready handshake.
//   Single-cycle ADD/SUB/AND/OR/XOR; SRA/SRL/SLL iterate one bit per cycle.
// Ports:
//   clk, rst_n (async low), flush (sync abort)
//   in_valid/in_ready, fs[2:0], op_a/op_b[WIDTH], shamt[SHW]  - request
//   out_valid/out_ready, result[WIDTH], carry, zero, neg, ovf - response
//   busy - unit not idle
module alu_seq_unit #(
  parameter int WIDTH = 12,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fs,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam logic [2:0] FS_ADD = 3'b000, FS_SUB = 3'b001, FS_SRA = 3'b010,
                         FS_SRL = 3'b011, FS_SLL = 3'b100, FS_AND = 3'b101,
                         FS_OR  = 3'b110, FS_XOR = 3'b111;
  localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2:0]         fs_q, fs_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic               accept, is_shift, fin, fin_c, fin_v;
  logic [WIDTH-1:0]   fin_val, b_op, step_val;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     cnt_sat;
  logic               step_out;

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

  assign accept   = in_valid && in_ready;
  assign is_shift = (fs == FS_SRA) || (fs == FS_SRL) || (fs == FS_SLL);
  assign cnt_sat  = (shamt > CNT_MAX) ? CNT_MAX : shamt;

  // SUB reuses the adder as A + ~B + 1, so carry-out means "no borrow".
  assign b_op = (fs == FS_SUB) ? ~op_b : op_b;
  assign sum  = {1'b0, op_a} + {1'b0, b_op} + (WIDTH+1)'(fs == FS_SUB);

  // One shift step on the working register; SRA replicates the MSB, which
  // stays equal to the original sign bit across all steps.
  always_comb begin
    step_val = {work_q[WIDTH-2:0], 1'b0};
    step_out = work_q[WIDTH-1];
    if (fs_q == FS_SRA) begin
      step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      step_out = work_q[0];
    end else if (fs_q == FS_SRL) begin
      step_val = {1'b0, work_q[WIDTH-1:1]};
      step_out = work_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    fs_d    = fs_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    fin     = 1'b0;
    fin_val = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          if (is_shift) begin
            work_d = op_a;
            fs_d   = fs;
            cnt_d  = cnt_sat;
            if (cnt_sat == '0) begin
              fin     = 1'b1;
              fin_val = op_a;
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            fin     = 1'b1;
            state_d = DONE;
            unique case (fs)
              FS_ADD, FS_SUB: begin
                fin_val = sum[WIDTH-1:0];
                fin_c   = sum[WIDTH];
                fin_v   = (op_a[WIDTH-1] == b_op[WIDTH-1]) &&
                          (sum[WIDTH-1] != op_a[WIDTH-1]);
              end
              FS_AND:  fin_val = op_a & op_b;
              FS_OR:   fin_val = op_a | op_b;
              default: fin_val = op_a ^ op_b;
            endcase
          end
        end
        SHIFT: begin
          work_d = step_val;
          cnt_d  = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            fin     = 1'b1;
            fin_val = step_val;
            fin_c   = step_out;
            state_d = DONE;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Result and flags only change when an operation completes.
    if (fin) begin
      res_d   = fin_val;
      carry_d = fin_c;
      ovf_d   = fin_v;
      zero_d  = (fin_val == '0);
      neg_d   = fin_val[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      fs_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares on each new result.
module tb_alu_seq_unit;
  localparam int W = 12, SH = 4;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [2:0]    fs = '0;
  logic [W-1:0]  op_a = '0, op_b = '0, result;
  logic [SH-1:0] shamt = '0;
  logic          carry, zero, neg, ovf, busy;

  alu_seq_unit #(.WIDTH(W), .SHW(SH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .fs(fs), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic c, z, n, v;
    int acc, lat, id;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitor: compare on the first cycle of each result, then check it is
  // held stable (and no new request is admitted) while the consumer stalls.
  logic pv = 1'b0;
  exp_t cur;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && !pv) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual=0x%0h required=none", result);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("op%0d_result", e.id), 32'(result), 32'(e.res));
        chk($sformatf("op%0d_carry", e.id), 32'(carry), 32'(e.c));
        chk($sformatf("op%0d_zero", e.id), 32'(zero), 32'(e.z));
        chk($sformatf("op%0d_neg", e.id), 32'(neg), 32'(e.n));
        chk($sformatf("op%0d_ovf", e.id), 32'(ovf), 32'(e.v));
        chk($sformatf("op%0d_latency", e.id), 32'(cyc - e.acc), 32'(e.lat));
        cur <= e;
      end
    end else if (rst_n && out_valid && pv) begin
      chk($sformatf("op%0d_hold_result", cur.id), 32'(result), 32'(cur.res));
      chk($sformatf("op%0d_hold_flags", cur.id), 32'({carry, zero, neg, ovf}),
          32'({cur.c, cur.z, cur.n, cur.v}));
    end
    if (rst_n && out_valid && !out_ready)
      chk("in_ready_while_stalled", 32'(in_ready), 32'd0);
    pv <= out_valid;
  end

  int nid = 0;

  // Present a request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SH-1:0] s, input logic [W-1:0] r,
                       input logic c, input logic z, input logic n, input logic v,
                       input int lat, output int acc);
    exp_t e;
    int k = 0;
    fs = f; op_a = a; op_b = b; shamt = s; in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
    acc = cyc;
    e.res = r; e.c = c; e.z = z; e.n = n; e.v = v;
    e.acc = acc; e.lat = lat; e.id = nid++;
    sbq.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  int acc, acc2, hs;

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", 32'({result, carry, zero, neg, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fs  a       b       sh     result  c  z  n  v  lat
    issue(3'b000, 12'h7FF, 12'h001, 4'd0, 12'h800, 0, 0, 1, 1, 1, acc);   // ADD overflow
    issue(3'b001, 12'h005, 12'h005, 4'd0, 12'h000, 1, 1, 0, 0, 1, acc);   // SUB equal
    issue(3'b001, 12'h003, 12'h005, 4'd0, 12'hFFE, 0, 0, 1, 0, 1, acc);   // SUB borrow
    issue(3'b111, 12'hAAA, 12'h0FF, 4'd0, 12'hA55, 0, 0, 1, 0, 1, acc);   // XOR
    issue(3'b110, 12'h0F0, 12'h00F, 4'd0, 12'h0FF, 0, 0, 0, 0, 1, acc);   // OR

    issue(3'b010, 12'h880, 12'h000, 4'd3, 12'hF10, 0, 0, 1, 0, 4, acc);   // SRA 3
    for (int i = 0; i < 3; i++) begin
      chk("sra_in_ready_low", 32'(in_ready), 32'd0);
      chk("sra_busy_high", 32'(busy), 32'd1);
      chk("sra_no_early_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    issue(3'b100, 12'hC01, 12'h000, 4'd2, 12'h004, 1, 0, 0, 0, 3, acc);   // SLL 2
    issue(3'b011, 12'hFFF, 12'h000, 4'd15, 12'h000, 1, 1, 0, 0, 13, acc); // SRL saturated
    issue(3'b010, 12'h923, 12'h000, 4'd0, 12'h923, 0, 0, 1, 0, 1, acc);   // shamt 0

    // Stall the consumer for 5 cycles with the next request already waiting.
    drain();
    out_ready = 1'b0;
    issue(3'b101, 12'hF0F, 12'h3C3, 4'd0, 12'h303, 0, 0, 0, 0, 1, acc);   // AND
    fork
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        hs = cyc;
      end
      issue(3'b000, 12'h001, 12'hFFF, 4'd0, 12'h000, 1, 1, 0, 0, 1, acc2);
    join
    chk("accept_after_handshake", 32'(acc2), 32'(hs + 1));
    drain();

    // Asynchronous reset in the middle of a shift.
    issue(3'b011, 12'hABC, 12'h000, 4'd10, 12'h000, 0, 0, 0, 0, 11, acc);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_outputs", 32'({result, carry, zero, neg, ovf}), 32'd0);
    sbq.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Flush while a result waits for the consumer.
    out_ready = 1'b0;
    issue(3'b000, 12'h100, 12'h200, 4'd0, 12'h300, 0, 0, 0, 0, 1, acc);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    issue(3'b111, 12'h555, 12'h555, 4'd0, 12'h000, 0, 1, 0, 0, 1, acc);   // XOR zero
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, multi-cycle successor to the 12-bit CPU's combinational ALU function-select decoder.
- Decodes the 3-bit function select, executes the operation, and returns the result with status flags through a valid/ready handshake.
- Add/sub/logic complete in one cycle; shifts are iterative, one bit per cycle, with a variable shift amount.
- Adds XOR (FS=111) to the existing op set.

Parameters:
- WIDTH, 12: datapath width in bits (min 4).
- SHW, 4: shift-amount port width; must satisfy 2^SHW > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; discards any operation in flight.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request.
- fs  in  3  function select: 000 ADD, 001 SUB, 010 SRA, 011 SRL, 100 SLL, 101 AND, 110 OR, 111 XOR.
- op_a  in  WIDTH  operand A; the shift source for shift ops.
- op_b  in  WIDTH  operand B; ignored for shifts.
- shamt  in  SHW  shift amount; ignored for non-shift ops.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- carry  out  1  carry / no-borrow / last bit shifted out.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- ovf  out  1  signed overflow.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: rst_n low forces state IDLE immediately. result, carry, zero, neg, ovf, out_valid, busy and the internal counter all go to 0. in_ready = 1 (IDLE). Reset mid-operation discards the operation; no partial result is ever presented.
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE) and !flush. out_valid = (state == DONE). busy = (state != IDLE).
- Accept: in_valid & in_ready at a rising edge. op_a, op_b, fs and shamt are captured on that edge.
- Non-shift ops: computed on the accept edge, then IDLE -> DONE. out_valid is high in the cycle after acceptance (latency 1).
- ADD: A + B. carry = carry-out; ovf = signed overflow.
- SUB: A + ~B + 1. carry = 1 when A >= B unsigned (no borrow); ovf = signed overflow.
- AND, OR, XOR: bitwise. carry = 0, ovf = 0.
- Shifts: on the accept edge, working register = op_a and count = min(shamt, WIDTH).
  - If count == 0: go to DONE with result = op_a, carry = 0.
  - Otherwise go to SHIFT. Each edge in SHIFT shifts the working register by 1 and decrements count. The bit shifted out is recorded as carry.
  - The edge that decrements count to 0 moves to DONE.
  - out_valid first rises in cycle 1 + min(shamt, WIDTH) after the accept cycle.
  - SRA fills with the original sign bit; SRL and SLL fill with 0. shamt >= WIDTH saturates to WIDTH cycles.
  - ovf = 0 for all shifts.
- Flags: zero and neg are always derived from the final result.
- DONE: result and flags held stable while out_valid & !out_ready. On out_valid & out_ready the state goes to IDLE and out_valid drops the next cycle. A new request can be accepted in the cycle after the handshake; there is no same-cycle overlap.
- flush: synchronous, priority over every transition. In any state it moves to IDLE at the next edge. A request presented while flush is high is not accepted.
- Outputs are registered. result and flags keep their last value in IDLE. Consumers qualify them with out_valid only.

Test Plan:
1. ADD 0x7FF + 0x001 -> result 0x800, ovf=1, neg=1, carry=0, zero=0; out_valid in cycle accept+1. SUB 0x005 - 0x005 -> 0x000, zero=1, carry=1.
2. SUB 0x003 - 0x005 -> 0xFFE, carry=0, neg=1, ovf=0. XOR 0xAAA ^ 0x0FF -> 0xA55. OR 0x0F0 | 0x00F -> 0x0FF. All with carry=0.
3. SRA 0x880, shamt=3 -> 0xF10, carry=0; out_valid first high exactly 4 cycles after accept, with in_ready=0 and busy=1 throughout. SLL 0xC01, shamt=2 -> 0x004, carry=1.
4. SRL 0xFFF, shamt=15 -> saturates to 12 shifts; result 0x000, carry=1, zero=1; out_valid in cycle accept+13. shamt=0 -> result=op_a, carry=0, latency 1.
5. Hold out_ready=0 for 5 cycles after out_valid -> result and flags unchanged and in_ready=0. Keep in_valid asserted with the next request -> it is accepted in the cycle after the out_ready handshake.
6. rst_n pulsed low mid-SHIFT -> all outputs 0 and state IDLE without waiting for a clock. flush asserted in DONE -> out_valid drops next cycle with no handshake, and in_ready returns to 1.
